// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI-lite definitions: response codes, default
//               protection attributes and the master bridge state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] AXIL_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_EXOKAY = 2'b01;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_DECERR = 2'b11;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  // Master bridge FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RD_A  = 3'd3,
    RD_D  = 3'd4
  } axil_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_bridge
// Description : Turns a single-outstanding request/response interface into
//               AXI-lite master reads (AR->R) and writes (AW+W->B). The
//               completion is returned as a one-cycle rsp_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // AXI-lite write address
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // AXI-lite write data
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // AXI-lite write response
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // AXI-lite read address
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // AXI-lite read data
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  axil_mst_state_t       state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  bready_q,    bready_d;
  logic                  arvalid_q,   arvalid_d;
  logic                  rready_q,    rready_d;
  logic                  aw_done_q,   aw_done_d;
  logic                  w_done_q,    w_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic w_aw_hs;
  logic w_w_hs;

  assign w_aw_hs = awvalid_q && m_axil_awready;
  assign w_w_hs  = wvalid_q  && m_axil_wready;

  // Next-state and next-output logic; every register holds unless told otherwise
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W retire independently; each valid drops after its own handshake
        if (w_aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // bready only once both halves of the write have been accepted
        if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (m_axil_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axil_bresp != AXIL_OKAY);
          state_d     = IDLE;
        end
      end
      RD_A: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (m_axil_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_err_d   = (m_axil_rresp != AXIL_OKAY);
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = AXIL_PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = AXIL_PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_master_bridge
// Description : Self-checking bench for axil_master_bridge with an AXI-lite
//               RAM responder (programmable ready delays, error codes, early
//               bvalid, withheld rvalid) and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  // ---------------- responder (16-word RAM) ----------------
  int         aw_dly = 0, w_dly = 0, ar_dly = 0;
  int         aw_cnt, w_cnt, ar_cnt;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  bit         early_b = 1'b0, r_hold = 1'b0;
  logic [31:0] ram [0:15];
  logic        aw_got, w_got;
  logic [15:0] aw_lat;
  logic [31:0] w_lat;
  logic [3:0]  s_lat;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk) begin : responder
    logic        ag, wg;
    logic [15:0] ta;
    logic [31:0] td;
    logic [3:0]  ts;
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
      rdata <= '0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_lat <= '0; w_lat <= '0; s_lat <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      ag = aw_got; wg = w_got; ta = aw_lat; td = w_lat; ts = s_lat;
      if (bvalid && bready) bvalid <= 1'b0;
      if (awvalid && awready) begin
        ag = 1'b1; ta = awaddr;
        if (early_b) begin bvalid <= 1'b1; bresp <= cfg_bresp; end
      end
      if (wvalid && wready) begin wg = 1'b1; td = wdata; ts = wstrb; end
      if (ag && wg) begin
        for (int i = 0; i < 4; i++)
          if (ts[i]) ram[ta[5:2]][8*i +: 8] = td[8*i +: 8];
        ag = 1'b0; wg = 1'b0;
        if (!early_b) begin bvalid <= 1'b1; bresp <= cfg_bresp; end
      end
      aw_got <= ag; w_got <= wg; aw_lat <= ta; w_lat <= td; s_lat <= ts;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready && !r_hold) begin
        rvalid <= 1'b1; rdata <= ram[araddr[5:2]]; rresp <= cfg_rresp;
      end
    end
  end

  // ---------------- scoreboard and protocol monitor ----------------
  typedef struct { bit we; logic [31:0] rd; bit err; int acc; int lat; } exp_t;
  exp_t        sb[$];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, rsp_cnt = 0, viol = 0;
  logic [31:0] last_rd = '0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv;
  logic [15:0] p_awa, p_ara;
  logic [31:0] p_wd;
  logic [3:0]  p_ws;

  always @(posedge clk) cyc <= cyc + 1;

  // Pops an expectation for each response pulse and watches AXI rules
  always @(negedge clk) begin
    if (rst) begin
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rspv = 0;
      p_awa = '0; p_ara = '0; p_wd = '0; p_ws = '0;
    end else begin
      if (rsp_valid) begin
        exp_t e;
        rsp_cnt++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL rsp_unexpected: got rsp_valid, required no response");
        else begin
          n_pass++;
          e = sb.pop_front();
          n_checks++;
          if (rsp_rdata !== e.rd) $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e.rd);
          else n_pass++;
          n_checks++;
          if (rsp_err !== e.err) $display("FAIL rsp_err: got %b required %b", rsp_err, e.err);
          else n_pass++;
          if (e.lat != 0) begin
            n_checks++;
            if ((cyc - e.acc) !== e.lat) $display("FAIL rsp_latency: got %0d required %0d", cyc - e.acc, e.lat);
            else n_pass++;
          end
        end
      end
      if (p_rspv && rsp_valid) viol++;
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awa)) viol++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) viol++;
      if (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) viol++;
      if (bready && (awvalid || wvalid)) viol++;
      if (awprot !== 3'b000 || arprot !== 3'b000) viol++;
      p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
      p_arv = arvalid; p_arr = arready; p_rspv = rsp_valid;
      p_awa = awaddr; p_ara = araddr; p_wd = wdata; p_ws = wstrb;
    end
  end

  // ---------------- request helpers ----------------
  task automatic issue(input bit we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] erd, input bit eerr,
                       input int elat);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    if (!we) last_rd = erd;
    e.we = we; e.rd = last_rd; e.err = eerr; e.acc = cyc; e.lat = elat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start);
    int n = 0;
    while (rsp_cnt == start && n < 50) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (rsp_cnt == start) $display("FAIL rsp_timeout: got no response, required one within 50 cycles");
    else n_pass++;
  endtask

  task automatic do_req(input bit we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] erd, input bit eerr);
    int st;
    st = rsp_cnt;
    issue(we, a, d, s, erd, eerr, 0);
    wait_rsp(st);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready); else n_pass++;
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b required 0000000",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err});
    else n_pass++;
    n_checks++;
    if ({rsp_rdata, awaddr, wdata, wstrb} !== '0)
      $display("FAIL reset_data: got rdata %h addr %h wdata %h required 0", rsp_rdata, awaddr, wdata);
    else n_pass++;
  endtask

  task automatic test_write_basic;
    int st;
    st = rsp_cnt;
    issue(1'b1, 16'h0000, 32'hA5000012, 4'hF, 32'h0, 1'b0, 3);
    n_checks++;
    if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 16'h0000, 32'hA5000012})
      $display("FAIL wr_cycle1: got aw %b w %b addr %h data %h required 1 1 0000 a5000012",
               awvalid, wvalid, awaddr, wdata);
    else n_pass++;
    wait_rsp(st);
  endtask

  task automatic test_read_basic;
    int st;
    st = rsp_cnt;
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'hA5000012, 1'b0, 3);
    n_checks++;
    if (arvalid !== 1'b1 || araddr !== 16'h0000)
      $display("FAIL rd_cycle1: got arvalid %b addr %h required 1 0000", arvalid, araddr);
    else n_pass++;
    wait_rsp(st);
  endtask

  task automatic test_write_stall;
    int st;
    do_req(1'b1, 16'h0004, 32'h11223344, 4'hF, 32'h0, 1'b0);
    aw_dly = 3;
    st = rsp_cnt;
    issue(1'b1, 16'h0004, 32'hFFFFFFFF, 4'b0010, 32'h0, 1'b0, 0);
    @(posedge clk); #1;
    n_checks++;
    if ({wvalid, awvalid, bready} !== 3'b010 || awaddr !== 16'h0004)
      $display("FAIL wr_stall_cycle2: got w %b aw %b b %b addr %h required 0 1 0 0004",
               wvalid, awvalid, bready, awaddr);
    else n_pass++;
    wait_rsp(st);
    aw_dly = 0;
    do_req(1'b0, 16'h0004, 32'h0, 4'h0, 32'h1122FF44, 1'b0);
  endtask

  task automatic test_errors;
    cfg_bresp = 2'b10;
    do_req(1'b1, 16'h0008, 32'h00000005, 4'hF, 32'h0, 1'b1);
    cfg_bresp = 2'b00;
    cfg_rresp = 2'b11;
    do_req(1'b0, 16'h0008, 32'h0, 4'h0, 32'h00000005, 1'b1);
    cfg_rresp = 2'b00;
    do_req(1'b0, 16'h0008, 32'h0, 4'h0, 32'h00000005, 1'b0);
    do_req(1'b1, 16'h0008, 32'h00000006, 4'hF, 32'h0, 1'b0);
  endtask

  task automatic test_early_b;
    int st;
    early_b = 1'b1; w_dly = 3;
    st = rsp_cnt;
    do_req(1'b1, 16'h000C, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (rsp_cnt - st !== 1) $display("FAIL early_b_pulses: got %0d required 1", rsp_cnt - st);
    else n_pass++;
    early_b = 1'b0; w_dly = 0;
    do_req(1'b0, 16'h000C, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_back_to_back;
    int st, n;
    st = rsp_cnt;
    issue(1'b1, 16'h0010, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 3);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b1)
      $display("FAIL b2b_ready: got req_ready %b rsp_valid %b required 1 1", req_ready, rsp_valid);
    else n_pass++;
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 3);
    wait_rsp(st + 1);
  endtask

  task automatic test_reset_mid;
    r_hold = 1'b1;
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'hA5000012, 1'b0, 0);
    @(posedge clk); #1;
    n_checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0)
      $display("FAIL rst_mid_rd_d: got rready %b arvalid %b required 1 0", rready, arvalid);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    last_rd = '0;
    r_hold = 1'b0;
    n_checks++;
    if ({arvalid, rready, rsp_valid, req_ready} !== 4'b0001 || rsp_rdata !== 32'h0)
      $display("FAIL rst_mid_state: got ar %b r %b rsp %b rdy %b rdata %h required 0 0 0 1 0",
               arvalid, rready, rsp_valid, req_ready, rsp_rdata);
    else n_pass++;
    do_req(1'b0, 16'h0000, 32'h0, 4'h0, 32'hA5000012, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_stall();
    test_errors();
    test_early_b();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (viol !== 0) $display("FAIL protocol_rules: got %0d violations required 0", viol);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL sb_drained: got %0d pending required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- Converts the core's simple single-outstanding memory request interface into AXI-lite master transactions.
- Drives AXI-lite peripherals such as the RAM, the 7-segment display and the perf counters.
- Handles one transaction at a time: a write (AW+W→B) or a read (AR→R).
- Returns read data or write completion to the requester as a one-cycle response pulse.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 16, address bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  STRB_WIDTH  byte enables
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads
- rsp_err  out  1  response code was not OKAY
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel
- m_axil_awready  in  1
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  write data channel
- m_axil_wready  in  1
- m_axil_bresp/bvalid  in  2/1; m_axil_bready  out  1  write response channel
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel
- m_axil_arready  in  1
- m_axil_rdata/rresp/rvalid  in  DATA_WIDTH/2/1; m_axil_rready  out  1  read data channel

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - All AXI valid/ready outputs 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Address and data registers 0.
  - req_ready=1 in the cycle after reset deasserts.
- All outputs are registered, except req_ready, which is (state==IDLE).
- awprot and arprot are constant 3'b000.
- FSM states: IDLE, WR, WRESP, RD_A, RD_D.
- IDLE:
  - On req_valid && req_ready, latch addr, wdata, wstrb.
  - req_we=1: go to WR, asserting awvalid=wvalid=1 the next cycle.
  - req_we=0: go to RD_A, asserting arvalid=1 the next cycle.
- WR:
  - awvalid drops the cycle after its own awready handshake; wvalid likewise with wready, independently.
  - aw_done and w_done flags record each handshake.
  - AW and W may complete in the same cycle or in either order.
  - When both are done (counting handshakes in the current cycle), go to WRESP with bready=1 the next cycle.
- WRESP:
  - bready held 1 until bvalid.
  - On bvalid && bready: bready←0, rsp_valid←1, rsp_err←(bresp!=2'b00), go to IDLE.
- RD_A:
  - arvalid held until arready.
  - Then arvalid←0, rready←1, go to RD_D.
- RD_D:
  - On rvalid && rready: rready←0, rsp_rdata←rdata, rsp_err←(rresp!=2'b00), rsp_valid←1, go to IDLE.
- Valid and payload stability: address, data and strobe are held stable while the corresponding valid is high. No valid is ever withdrawn before its handshake.
- bready is never asserted before both AW and W have completed. A bvalid arriving earlier is ignored until then.
- rsp_valid:
  - High for exactly one cycle per accepted request. No backpressure.
  - rsp_rdata holds its value until the next read completes.
  - Write completions leave rsp_rdata unchanged.
- Back-to-back: a new request is accepted in the same cycle rsp_valid is high, since state is IDLE.
- Minimum latency with zero-wait responder, accept at cycle 0:
  - Write: AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: AR cycle 1, R cycle 2, rsp_valid cycle 3.
- Reset mid-transaction:
  - Abandon immediately; next cycle is the reset state.
  - Responder is reset on the same rst, so no orphaned beats are expected.

Decomposition:
- Shared package axil_pkg:
  - Response codes AXIL_OKAY=2'b00, AXIL_EXOKAY=2'b01, AXIL_SLVERR=2'b10, AXIL_DECERR=2'b11.
  - AXIL_PROT_DEFAULT=3'b000.
  - State enum axil_mst_state_t.
- No sub-module: a single FSM is sufficient.

Test Plan:
- Write 0x0000 data 0xA5000012 strb 4'hF, zero-wait RAM responder → AW/W at cycle 1, rsp_valid at cycle 3, rsp_err=0; RAM word0=0xA5000012.
- Read 0x0000 after that write → rsp_rdata=0xA5000012, rsp_err=0, rsp_valid exactly one cycle.
- Write 0x0004 data 0xFFFFFFFF strb 4'b0010 onto word 0x11223344, with awready delayed 3 cycles and wready 0 cycles → wvalid drops after 1 cycle, awvalid held with stable addr, bready only after AW done; read back 0x1122FF44.
- Responder returns bresp=2'b10 on a write and rresp=2'b11 on a read → rsp_err=1 both times; next OKAY access → rsp_err=0.
- Responder raises bvalid early (before W handshake) → bready stays 0 until both AW and W are done; exactly one rsp_valid.
- Assert rst for 1 cycle while in RD_D with rvalid withheld → next cycle arvalid=rready=rsp_valid=0, req_ready=1; a following read of 0x0000 completes normally.
